vga_sync_decoder: RTL and testbench
===================================

Name: vga_sync_decoder

Overview:
- Receive end of the 640x480 VGA timing interface: consumes HS/VS as produced by the display timing generator (or an external source), recovers pixel coordinates and checks timing against the 640x480@60 mode.
- Sits beside the display chain as an on-chip loopback monitor. Lock and sticky error flags drive debug LEDs and the game logic's video-ready gate.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, HS pulse width (pixels)
- H_BP, 48, horizontal back porch; H_TOTAL = sum = 800
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VS pulse width (lines)
- V_BP, 33, vertical back porch; V_TOTAL = 525
- SYNC_ACTIVE_LOW, 1, 1: syncs asserted when low; 0: asserted when high
- LOCK_FRAMES, 2, consecutive good frames required for lock

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_pix_stb  in  1  pixel strobe; all state advances only on cycles where it is 1
- i_hs  in  1  horizontal sync in
- i_vs  in  1  vertical sync in
- i_err_clr  in  1  clears sticky error bits
- o_x  out  10  recovered x (0..H_TOTAL-1)
- o_y  out  10  recovered y (0..V_TOTAL-1)
- o_active  out  1  locked & o_x<H_ACTIVE & o_y<V_ACTIVE
- o_sof  out  1  one-clock pulse when locked and (o_x,o_y) becomes (0,0)
- o_locked  out  1  timing lock
- o_err  out  3  sticky: [0] line length, [1] HS width, [2] frame length / VS width

Behaviour:
- Reset values: all outputs 0. Internal sync-history registers reset to the asserted level, so a sync held asserted through reset release gives no edge. All internal counters reset to 0. "Seen" flags reset to 0.
- Syncs are normalised to an asserted-high internal level using SYNC_ACTIVE_LOW.
- On cycles with i_pix_stb=0, nothing changes. o_sof is forced to 0 on those cycles.
- Sampling: on each strobe, i_hs and i_vs are sampled and the previous samples are kept.
  - HS assert edge = previous sample deasserted and current sample asserted.
  - VS edges are defined the same way.
- X recovery: on an HS assert edge, o_x <= H_ACTIVE+H_FP (656). Otherwise o_x <= (o_x==H_TOTAL-1) ? 0 : o_x+1. Latency is 1 clk from the strobe carrying the sample.
- Y recovery: on a VS assert edge, o_y <= V_ACTIVE+V_FP (490). Otherwise, whenever o_x wraps to 0, o_y <= (o_y==V_TOTAL-1) ? 0 : o_y+1. If a VS edge coincides with an x wrap, the VS edge wins.
- Line length check:
  - An 11-bit strobe counter restarts at 1 on each HS assert edge and saturates at 2047.
  - At every HS assert edge after the first since reset, if count != H_TOTAL then set o_err[0].
- HS width check:
  - An 8-bit counter counts asserted strobes and saturates at 255.
  - On the HS deassert edge, if count != H_SYNC then set o_err[1].
- Frame check:
  - A 10-bit counter counts HS assert edges between VS assert edges.
  - At every VS assert edge after the first, if count != V_TOTAL then set o_err[2].
  - HS edges counted while VS is asserted must equal V_SYNC at the VS deassert edge; otherwise set o_err[2].
- Lock FSM has three states: UNLOCKED, TRAINING, LOCKED.
  - UNLOCKED -> TRAINING on the first VS assert edge. The good-frame count is cleared.
  - At each later VS assert edge, a frame is good if no check failed since the previous VS edge. Good frames increment the count.
  - Count reaching LOCK_FRAMES -> LOCKED; o_locked=1 on the next clock.
  - Any check failure in TRAINING or LOCKED -> TRAINING with count 0. o_locked drops on the clock after the failing strobe.
- Sticky errors:
  - Bits are cleared by i_err_clr=1, which is honoured on any clock regardless of strobe.
  - If a clear and a new error occur in the same clock, the error bit ends set.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). Recovery waits for a fresh HS/VS edge.

Test Plan:
- Nominal 640x480 generator loopback from reset:
  - o_x=656 one clock after the first strobe with HS low.
  - o_locked=1 one clock after the 3rd VS assert edge.
  - o_err=0 throughout.
  - o_sof pulses exactly once per 420000 strobes.
- After lock, stretch one line to 801 strobes:
  - o_err[0]=1 and o_locked=0 one clock after the next HS edge.
  - Relock after 2 further good frames; o_err[0] stays 1 until i_err_clr.
- After lock, shorten one HS pulse to 95 strobes: o_err[1]=1 and o_locked=0; o_err[0] unchanged.
- Frame of 526 lines: o_err[2]=1 at the following VS edge. Then assert i_err_clr in the same clock as a new line-length error: o_err[0]=1 and o_err[2]=0 afterwards.
- Assert i_rst mid-line with HS low: all outputs 0 immediately. Release with HS still low: o_x stays 0 until HS goes high then low again.
- Hold i_pix_stb=0 for 100 clocks mid-frame: o_x, o_y, o_err and o_locked unchanged; o_sof=0.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: receive-side monitor for 640x480 VGA timing.
//
// Samples HS/VS on each pixel strobe, recovers the pixel position from the
// sync edges, checks line length, HS width, frame length and VS width
// against the configured mode, and tracks timing lock over whole frames.
//
// Ports:
//   i_clk      system clock
//   i_rst      asynchronous active-high reset
//   i_pix_stb  pixel strobe; state advances only when high
//   i_hs/i_vs  incoming syncs (polarity set by SYNC_ACTIVE_LOW)
//   i_err_clr  clears sticky error bits, honoured on any clock
//   o_x/o_y    recovered pixel position
//   o_active   locked and inside the visible area
//   o_sof      one-clock pulse when locked and the position becomes (0,0)
//   o_locked   timing lock
//   o_err      sticky: [0] line length, [1] HS width, [2] frame length/VS width
module vga_sync_decoder #(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned H_FP            = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BP            = 48,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned V_FP            = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BP            = 33,
  parameter int unsigned SYNC_ACTIVE_LOW = 1,
  parameter int unsigned LOCK_FRAMES     = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_stb,
  input  logic       i_hs,
  input  logic       i_vs,
  input  logic       i_err_clr,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_active,
  output logic       o_sof,
  output logic       o_locked,
  output logic [2:0] o_err
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  XStart     = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  XLast      = 10'(H_TOTAL - 1);
  localparam logic [9:0]  XVisible   = 10'(H_ACTIVE);
  localparam logic [9:0]  YStart     = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  YLast      = 10'(V_TOTAL - 1);
  localparam logic [9:0]  YVisible   = 10'(V_ACTIVE);
  localparam logic [10:0] LineLen    = 11'(H_TOTAL);
  localparam logic [7:0]  HsWidth    = 8'(H_SYNC);
  localparam logic [9:0]  FrameLen   = 10'(V_TOTAL);
  localparam logic [9:0]  VsWidth    = 10'(V_SYNC);
  localparam logic [7:0]  GoodTarget = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    StUnlocked,
    StTraining,
    StLocked
  } lock_state_e;

  lock_state_e state_q, state_d;

  logic        hs_prev_q, hs_prev_d;
  logic        vs_prev_q, vs_prev_d;
  logic        h_seen_q, h_seen_d;
  logic        v_seen_q, v_seen_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [10:0] line_cnt_q, line_cnt_d;
  logic [7:0]  hsw_cnt_q, hsw_cnt_d;
  logic [9:0]  frame_cnt_q, frame_cnt_d;
  logic [9:0]  vsw_cnt_q, vsw_cnt_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic        frame_bad_q, frame_bad_d;
  logic [2:0]  err_q, err_d;
  logic        sof_q, sof_d;

  logic       hs_lvl, vs_lvl;
  logic       hs_rise, hs_fall, vs_rise, vs_fall;
  logic       x_wrap;
  logic [2:0] err_set;
  logic       check_fail;

  // Internal sync level is always asserted-high.
  assign hs_lvl = (SYNC_ACTIVE_LOW != 0) ? ~i_hs : i_hs;
  assign vs_lvl = (SYNC_ACTIVE_LOW != 0) ? ~i_vs : i_vs;

  assign hs_rise = i_pix_stb & hs_lvl & ~hs_prev_q;
  assign hs_fall = i_pix_stb & ~hs_lvl & hs_prev_q;
  assign vs_rise = i_pix_stb & vs_lvl & ~vs_prev_q;
  assign vs_fall = i_pix_stb & ~vs_lvl & vs_prev_q;

  // x rolls over to 0 by counting, not by being re-aligned to an HS edge.
  assign x_wrap = i_pix_stb & h_seen_q & ~hs_rise & (x_q == XLast);

  // Position recovery and timing checks.
  always_comb begin
    hs_prev_d   = hs_prev_q;
    vs_prev_d   = vs_prev_q;
    h_seen_d    = h_seen_q;
    v_seen_d    = v_seen_q;
    x_d         = x_q;
    y_d         = y_q;
    line_cnt_d  = line_cnt_q;
    hsw_cnt_d   = hsw_cnt_q;
    frame_cnt_d = frame_cnt_q;
    vsw_cnt_d   = vsw_cnt_q;
    err_set     = 3'b000;

    if (i_pix_stb) begin
      hs_prev_d = hs_lvl;
      vs_prev_d = vs_lvl;

      // Counting only starts once a real HS edge has aligned x.
      if (hs_rise) begin
        x_d      = XStart;
        h_seen_d = 1'b1;
      end else if (h_seen_q) begin
        x_d = (x_q == XLast) ? 10'd0 : x_q + 10'd1;
      end

      // A VS edge takes priority over a coincident x wrap.
      if (vs_rise) begin
        y_d      = YStart;
        v_seen_d = 1'b1;
      end else if (x_wrap && v_seen_q) begin
        y_d = (y_q == YLast) ? 10'd0 : y_q + 10'd1;
      end

      // Line length: strobes from one HS assert edge to the next.
      if (hs_rise) begin
        if (h_seen_q && (line_cnt_q != LineLen)) err_set[0] = 1'b1;
        line_cnt_d = 11'd1;
      end else if (line_cnt_q != '1) begin
        line_cnt_d = line_cnt_q + 11'd1;
      end

      // HS width: asserted strobes since the assert edge.
      if (hs_rise) begin
        hsw_cnt_d = 8'd1;
      end else if (hs_lvl && (hsw_cnt_q != '1)) begin
        hsw_cnt_d = hsw_cnt_q + 8'd1;
      end
      if (hs_fall) begin
        if (h_seen_q && (hsw_cnt_q != HsWidth)) err_set[1] = 1'b1;
        hsw_cnt_d = 8'd0;
      end

      // Frame length: HS assert edges from one VS assert edge to the next.
      if (vs_rise) begin
        if (v_seen_q && (frame_cnt_q != FrameLen)) err_set[2] = 1'b1;
        frame_cnt_d = hs_rise ? 10'd1 : 10'd0;
      end else if (hs_rise && (frame_cnt_q != '1)) begin
        frame_cnt_d = frame_cnt_q + 10'd1;
      end

      // VS width in lines: HS assert edges while VS is asserted.
      if (vs_rise) begin
        vsw_cnt_d = hs_rise ? 10'd1 : 10'd0;
      end else if (hs_rise && vs_lvl && (vsw_cnt_q != '1)) begin
        vsw_cnt_d = vsw_cnt_q + 10'd1;
      end
      if (vs_fall) begin
        if (v_seen_q && (vsw_cnt_q != VsWidth)) err_set[2] = 1'b1;
        vsw_cnt_d = 10'd0;
      end
    end

    // A new error wins over a clear in the same clock.
    err_d = (err_q & ~{3{i_err_clr}}) | err_set;
  end

  assign check_fail = |err_set;

  // Lock tracking over whole frames.
  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    frame_bad_d = frame_bad_q;

    unique case (state_q)
      StUnlocked: begin
        if (vs_rise) begin
          state_d     = StTraining;
          good_cnt_d  = 8'd0;
          frame_bad_d = 1'b0;
        end
      end
      StTraining, StLocked: begin
        if (check_fail) begin
          state_d     = StTraining;
          good_cnt_d  = 8'd0;
          // A failure on the VS edge belongs to the frame that just ended.
          frame_bad_d = ~vs_rise;
        end else if (vs_rise) begin
          frame_bad_d = 1'b0;
          if (!frame_bad_q) begin
            if (good_cnt_q != '1) good_cnt_d = good_cnt_q + 8'd1;
            if (good_cnt_q + 8'd1 >= GoodTarget) state_d = StLocked;
          end
        end
      end
      default: state_d = StUnlocked;
    endcase
  end

  assign sof_d = i_pix_stb & (state_q == StLocked) & (x_d == 10'd0) & (y_d == 10'd0) &
                 ((x_q != 10'd0) | (y_q != 10'd0));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StUnlocked;
      // Asserted level, so a sync held through reset release gives no edge.
      hs_prev_q   <= 1'b1;
      vs_prev_q   <= 1'b1;
      h_seen_q    <= 1'b0;
      v_seen_q    <= 1'b0;
      x_q         <= 10'd0;
      y_q         <= 10'd0;
      line_cnt_q  <= 11'd0;
      hsw_cnt_q   <= 8'd0;
      frame_cnt_q <= 10'd0;
      vsw_cnt_q   <= 10'd0;
      good_cnt_q  <= 8'd0;
      frame_bad_q <= 1'b0;
      err_q       <= 3'b000;
      sof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hs_prev_q   <= hs_prev_d;
      vs_prev_q   <= vs_prev_d;
      h_seen_q    <= h_seen_d;
      v_seen_q    <= v_seen_d;
      x_q         <= x_d;
      y_q         <= y_d;
      line_cnt_q  <= line_cnt_d;
      hsw_cnt_q   <= hsw_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      vsw_cnt_q   <= vsw_cnt_d;
      good_cnt_q  <= good_cnt_d;
      frame_bad_q <= frame_bad_d;
      err_q       <= err_d;
      sof_q       <= sof_d;
    end
  end

  assign o_x      = x_q;
  assign o_y      = y_q;
  assign o_err    = err_q;
  assign o_sof    = sof_q;
  assign o_locked = (state_q == StLocked);
  assign o_active = o_locked & (x_q < XVisible) & (y_q < YVisible);

endmodule

// File: tb/tb_vga_sync_decoder.sv
module tb_vga_sync_decoder;

  // Reduced mode so that many frames fit in a short run.
  localparam int HA = 16, HFP = 2, HSW = 4, HBP = 3, HT = HA + HFP + HSW + HBP;
  localparam int VA = 8, VFP = 2, VSW = 2, VBP = 3, VT = VA + VFP + VSW + VBP;
  localparam int LF = 2;
  localparam int XS = HA + HFP;
  localparam int YS = VA + VFP;

  logic       clk = 1'b0;
  logic       rst, stb, hs, vs, clr;
  logic [9:0] o_x, o_y;
  logic       o_active, o_sof, o_locked;
  logic [2:0] o_err;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(LF)
  ) u_dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_pix_stb(stb),
    .i_hs     (hs),
    .i_vs     (vs),
    .i_err_clr(clr),
    .o_x      (o_x),
    .o_y      (o_y),
    .o_active (o_active),
    .o_sof    (o_sof),
    .o_locked (o_locked),
    .o_err    (o_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Timing source: position counters with per-line/per-frame overrides.
  int gx = 0, gy = 0;
  int len_cur = HT, hsw_cur = HSW, fl_cur = VT;
  int len_pend = HT, hsw_pend = HSW, fl_pend = VT;
  bit rnd_faults = 0, rnd_clr_en = 0, clr_on_hs = 0, last_h = 1;

  function automatic bit gen_hs();
    return (gx >= XS) && (gx < XS + hsw_cur);
  endfunction

  function automatic bit gen_vs();
    return (gy >= YS) && (gy < YS + VSW);
  endfunction

  task automatic gen_advance();
    if (gx == len_cur - 1) begin
      gx = 0;
      if (gy == fl_cur - 1) begin
        gy      = 0;
        fl_cur  = fl_pend;
        fl_pend = VT;
        if (rnd_faults && $urandom_range(3) == 0) fl_cur = VT - 1 + int'($urandom_range(2));
      end else begin
        gy++;
      end
      len_cur  = len_pend;
      hsw_cur  = hsw_pend;
      len_pend = HT;
      hsw_pend = HSW;
      if (rnd_faults && $urandom_range(29) == 0) len_cur = HT - 1 + int'($urandom_range(2));
      if (rnd_faults && $urandom_range(29) == 0) hsw_cur = HSW - 1 + int'($urandom_range(2));
    end else begin
      gx++;
    end
  endtask

  // Reference model: measures intervals between sync edges in strobe units.
  int  sidx, hs_rise_at, hs_rises, vs_mark, m_x, m_y, good;
  bit  m_hs_prev, m_vs_prev, m_h_seen, m_v_seen, armed, dirty, m_sof;
  bit  [2:0] m_err;

  function automatic bit m_locked();
    return armed && (good >= LF);
  endfunction

  task automatic model_reset();
    sidx = 0; hs_rise_at = 0; hs_rises = 0; vs_mark = 0; m_x = 0; m_y = 0; good = 0;
    m_hs_prev = 1; m_vs_prev = 1; m_h_seen = 0; m_v_seen = 0; armed = 0; dirty = 0;
    m_sof = 0; m_err = 0;
  endtask

  task automatic model_step(input bit s, input bit h, input bit v, input bit c);
    bit hr, hf, vr, vf, was_locked, wrapped, fail;
    bit [2:0] set;
    int ox, oy;
    set   = 3'b000;
    m_sof = 0;
    if (s) begin
      was_locked = m_locked();
      ox = m_x;
      oy = m_y;
      hr = h && !m_hs_prev;
      hf = !h && m_hs_prev;
      vr = v && !m_vs_prev;
      vf = !v && m_vs_prev;
      if (hr && m_h_seen && (sidx - hs_rise_at) != HT) set[0] = 1;
      if (hf && m_h_seen && (sidx - hs_rise_at) != HSW) set[1] = 1;
      if (vr && m_v_seen && (hs_rises - vs_mark) != VT) set[2] = 1;
      if (vf && m_v_seen && (hs_rises - vs_mark) != VSW) set[2] = 1;
      if (vr) vs_mark = hs_rises;
      if (hr) begin
        hs_rises++;
        hs_rise_at = sidx;
      end
      wrapped = m_h_seen && !hr && (ox == HT - 1);
      if (hr || m_h_seen) m_x = (XS + sidx - hs_rise_at) % HT;
      if (vr) m_y = YS;
      else if (wrapped && m_v_seen) m_y = (m_y + 1) % VT;
      m_h_seen = m_h_seen || hr;
      m_v_seen = m_v_seen || vr;
      m_hs_prev = h;
      m_vs_prev = v;
      sidx++;
      fail = |set;
      if (!armed) begin
        if (vr) begin
          armed = 1; good = 0; dirty = 0;
        end
      end else if (fail) begin
        good  = 0;
        dirty = !vr;
      end else if (vr) begin
        if (!dirty) good++;
        dirty = 0;
      end
      m_sof = was_locked && m_x == 0 && m_y == 0 && !(ox == 0 && oy == 0);
    end
    m_err = (c ? 3'b000 : m_err) | set;
  endtask

  int sof_dut = 0;

  task automatic compare_all();
    check_eq("x", int'(o_x), m_x);
    check_eq("y", int'(o_y), m_y);
    check_eq("err", int'(o_err), int'(m_err));
    check_eq("locked", int'(o_locked), int'(m_locked()));
    check_eq("active", int'(o_active), int'(m_locked() && m_x < HA && m_y < VA));
    check_eq("sof", int'(o_sof), int'(m_sof));
  endtask

  task automatic cycle(input bit s, input bit c);
    bit h, v, cc;
    cc = c;
    @(negedge clk);
    h = gen_hs();
    v = gen_vs();
    if (clr_on_hs && s && h && !last_h) begin
      cc = 1;
      clr_on_hs = 0;
    end
    stb = s; hs = ~h; vs = ~v; clr = cc;
    @(posedge clk);
    #1;
    model_step(s, h, v, cc);
    compare_all();
    if (o_sof) sof_dut++;
    if (s) begin
      last_h = h;
      gen_advance();
    end
  endtask

  function automatic bit rand_stb();
    return $urandom_range(3) != 0;
  endfunction

  function automatic bit rand_clr();
    return rnd_clr_en && ($urandom_range(299) == 0);
  endfunction

  task automatic run_to(input int tx, input int ty);
    int guard = 0;
    while (!(gx == tx && gy == ty)) begin
      cycle(rand_stb(), rand_clr());
      guard++;
      if (guard > 20000) begin
        check_eq("run_to_timeout", guard, 0);
        break;
      end
    end
  endtask

  task automatic next_vs_edge();
    run_to(0, YS);
    cycle(1, 0);
  endtask

  initial begin
    int hx, hy, he;
    rst = 1; stb = 0; hs = 1; vs = 1; clr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_x", int'(o_x), 0);
    check_eq("rst_y", int'(o_y), 0);
    check_eq("rst_err", int'(o_err), 0);
    check_eq("rst_locked", int'(o_locked), 0);
    check_eq("rst_sof", int'(o_sof), 0);
    @(negedge clk);
    rst = 0;

    // First HS assert edge aligns x.
    run_to(XS, 0);
    cycle(1, 0);
    check_eq("x_first_hs", int'(o_x), XS);

    // Lock after the third VS edge.
    next_vs_edge();
    next_vs_edge();
    check_eq("not_locked_2nd_vs", int'(o_locked), 0);
    next_vs_edge();
    check_eq("locked_3rd_vs", int'(o_locked), 1);
    check_eq("no_err_nominal", int'(o_err), 0);

    // One start-of-frame pulse per frame.
    sof_dut = 0;
    next_vs_edge();
    next_vs_edge();
    check_eq("sof_count", sof_dut, 2);

    // Stretched line.
    run_to(0, 3);
    len_pend = HT + 1;
    run_to(XS, 5);
    cycle(1, 0);
    check_eq("stretch_err", int'(o_err), 1);
    check_eq("stretch_unlock", int'(o_locked), 0);
    next_vs_edge();
    next_vs_edge();
    check_eq("stretch_one_good", int'(o_locked), 0);
    next_vs_edge();
    check_eq("stretch_relock", int'(o_locked), 1);
    check_eq("stretch_err_sticky", int'(o_err), 1);
    cycle(1, 1);
    check_eq("err_cleared", int'(o_err), 0);

    // Short HS pulse.
    run_to(0, 3);
    hsw_pend = HSW - 1;
    run_to(XS + HSW - 1, 4);
    cycle(1, 0);
    check_eq("short_hs_err", int'(o_err), 2);
    check_eq("short_hs_unlock", int'(o_locked), 0);
    for (int k = 0; k < 3; k++) next_vs_edge();
    check_eq("short_hs_relock", int'(o_locked), 1);

    // Strobe held low mid-frame.
    run_to(5, 5);
    hx = m_x; hy = m_y; he = int'(m_err);
    repeat (100) cycle(0, 0);
    check_eq("hold_x", int'(o_x), hx);
    check_eq("hold_y", int'(o_y), hy);
    check_eq("hold_err", int'(o_err), he);
    check_eq("hold_locked", int'(o_locked), 1);
    cycle(1, 1);

    // Frame one line too long.
    run_to(0, 3);
    fl_pend = VT + 1;
    next_vs_edge();
    next_vs_edge();
    check_eq("frame_ok_before_long", int'(o_err[2]), 0);
    next_vs_edge();
    check_eq("long_frame_err", int'(o_err[2]), 1);

    // Clear in the same clock as a new line-length error.
    run_to(0, 3);
    len_pend = HT + 1;
    run_to(XS + 1, 4);
    clr_on_hs = 1;
    run_to(XS + 1, 5);
    check_eq("clr_vs_new_err", int'(o_err), 1);

    // Asynchronous reset inside an HS pulse, released with HS still low.
    run_to(XS + 1, 2);
    @(negedge clk);
    stb = 0; hs = 0; rst = 1;
    #1;
    check_eq("arst_x", int'(o_x), 0);
    check_eq("arst_y", int'(o_y), 0);
    check_eq("arst_err", int'(o_err), 0);
    check_eq("arst_locked", int'(o_locked), 0);
    check_eq("arst_active", int'(o_active), 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    cycle(1, 0);
    check_eq("x_no_edge_after_rst", int'(o_x), 0);
    run_to(XS, 3);
    check_eq("x_wait_fresh_hs", int'(o_x), 0);
    cycle(1, 0);
    check_eq("x_fresh_hs", int'(o_x), XS);

    // Randomised line/frame faults and clears.
    rnd_faults = 1;
    rnd_clr_en = 1;
    repeat (6000) cycle(rand_stb(), rand_clr());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
